// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares one IO-register access port among NUM_REQ requesters (CPU, DMA
//   sequencer, debug/UART loader). Round-robin arbitration with a req/ack
//   handshake and a bounded lock so read-modify-write sequences stay atomic.
//
//   Ports:
//     clk_mem, rst        clock (rising edge) and synchronous active-high reset
//     req, lock           per-requester request level and keep-grant request
//     req_addr/wdata/     flattened per-requester transaction fields,
//     req_write/width     requester i at [i*W +: W]
//     ack                 one-cycle completion pulse to the granted requester
//     rdata               read data, valid while ack is high, held otherwise
//     grant_id            current or last granted requester
//     io_addr/data_in/    access port to the IO register file; io_data_out is
//     data_out/read/      its combinational read data
//     write/width
//
//   Each access is IDLE (arbitrate) -> ACCESS (strobe) -> RESP (ack). A locked
//   requester skips IDLE and goes RESP -> ACCESS directly, up to MAX_LOCK
//   consecutive accesses.
module io_bus_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic                      clk_mem,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*2-1:0]      req_width,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                grant_id,
    output logic [ADDR_W-1:0]         io_addr,
    output logic [DATA_W-1:0]         io_data_in,
    input  logic [DATA_W-1:0]         io_data_out,
    output logic                      io_read,
    output logic                      io_write,
    output logic [1:0]                io_width
);

    localparam int LCW = $clog2(MAX_LOCK) + 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t         state;
    logic [1:0]     last_grant;
    logic [LCW-1:0] lock_cnt;
    logic           rd_q;
    logic           wr_q;

    // Round-robin search starting just after the last granted index.
    logic [1:0] winner;
    always_comb begin
        int  idx;
        logic found;
        winner = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx[1:0];
            end
        end
    end

    // Fields are taken from the arbitration winner in IDLE, and from the
    // current owner when a lock carries it straight from RESP to ACCESS.
    logic [1:0]        sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_width;
    logic              sel_write;

    assign sel       = (state == IDLE) ? winner : grant_id;
    assign sel_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(sel)*DATA_W +: DATA_W];
    assign sel_width = req_width[int'(sel)*2 +: 2];
    assign sel_write = req_write[sel];

    logic lock_go;
    assign lock_go = req[grant_id] && lock[grant_id] && (lock_cnt < LOCK_LAST);

    // Strobes are registered but masked by rst so an access caught by reset
    // never commits on the closing edge.
    assign io_read  = rd_q & ~rst;
    assign io_write = wr_q & ~rst;

    always_ff @(posedge clk_mem) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'(NUM_REQ - 1);
            lock_cnt   <= '0;
            grant_id   <= '0;
            ack        <= '0;
            rdata      <= '0;
            io_addr    <= '0;
            io_data_in <= '0;
            io_width   <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            ack  <= '0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        io_addr    <= sel_addr;
                        io_data_in <= sel_wdata;
                        io_width   <= sel_width;
                        rd_q       <= ~sel_write;
                        wr_q       <= sel_write;
                        grant_id   <= winner;
                        last_grant <= winner;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!wr_q) rdata <= io_data_out;
                    ack   <= NUM_REQ'(1) << grant_id;
                    state <= RESP;
                end
                RESP: begin
                    if (lock_go) begin
                        lock_cnt   <= lock_cnt + 1'b1;
                        io_addr    <= sel_addr;
                        io_data_in <= sel_wdata;
                        io_width   <= sel_width;
                        rd_q       <= ~sel_write;
                        wr_q       <= sel_write;
                        state      <= ACCESS;
                    end else begin
                        lock_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Directed bench for io_bus_arbiter: a per-cycle vector table covering a
//   single read, 3-way contention and a MAX_LOCK lock burst, followed by
//   hand-written sequences for write passthrough, dropped request and reset
//   during a write access. The IO file is modelled as read data
//   {8'hA5, io_addr} so expected rdata follows from the address alone.
module tb_io_bus_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;

    logic                      clk_mem = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;
    logic [NUM_REQ-1:0][1:0]   width_a;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*2-1:0]      req_width;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [1:0]                grant_id;
    logic [ADDR_W-1:0]         io_addr;
    logic [DATA_W-1:0]         io_data_in;
    logic [DATA_W-1:0]         io_data_out;
    logic                      io_read;
    logic                      io_write;
    logic [1:0]                io_width;

    assign req_addr    = addr_a;
    assign req_wdata   = wdata_a;
    assign req_width   = width_a;
    assign io_data_out = {8'hA5, io_addr};

    io_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(4)) dut (
        .clk_mem(clk_mem), .rst(rst), .req(req), .lock(lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .req_width(req_width), .ack(ack), .rdata(rdata), .grant_id(grant_id),
        .io_addr(io_addr), .io_data_in(io_data_in), .io_data_out(io_data_out),
        .io_read(io_read), .io_write(io_write), .io_width(io_width)
    );

    always #5 clk_mem = ~clk_mem;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_mem);
        #1;
    endtask

    // One record per clock: inputs driven for the cycle, outputs expected
    // just after the closing edge.
    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic [2:0] ack;
        logic       rd;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl[24];

    initial begin
        // single read by requester 0
        tbl[0]  = '{3'b001, 3'b000, 3'b000, 1'b1, 2'd0};
        tbl[1]  = '{3'b001, 3'b000, 3'b001, 1'b0, 2'd0};
        tbl[2]  = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd0};
        // full contention: 1, 2, 0 at 3-cycle spacing
        tbl[3]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd1};
        tbl[4]  = '{3'b111, 3'b000, 3'b010, 1'b0, 2'd1};
        tbl[5]  = '{3'b111, 3'b000, 3'b000, 1'b0, 2'd1};
        tbl[6]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd2};
        tbl[7]  = '{3'b111, 3'b000, 3'b100, 1'b0, 2'd2};
        tbl[8]  = '{3'b111, 3'b000, 3'b000, 1'b0, 2'd2};
        tbl[9]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd0};
        tbl[10] = '{3'b111, 3'b000, 3'b001, 1'b0, 2'd0};
        tbl[11] = '{3'b111, 3'b000, 3'b000, 1'b0, 2'd0};
        // requester 2 locks while 0 also requests: 4 accesses then 0
        tbl[12] = '{3'b101, 3'b100, 3'b000, 1'b1, 2'd2};
        tbl[13] = '{3'b101, 3'b100, 3'b100, 1'b0, 2'd2};
        tbl[14] = '{3'b101, 3'b100, 3'b000, 1'b1, 2'd2};
        tbl[15] = '{3'b101, 3'b100, 3'b100, 1'b0, 2'd2};
        tbl[16] = '{3'b101, 3'b100, 3'b000, 1'b1, 2'd2};
        tbl[17] = '{3'b101, 3'b100, 3'b100, 1'b0, 2'd2};
        tbl[18] = '{3'b101, 3'b100, 3'b000, 1'b1, 2'd2};
        tbl[19] = '{3'b101, 3'b100, 3'b100, 1'b0, 2'd2};
        tbl[20] = '{3'b101, 3'b100, 3'b000, 1'b0, 2'd2};
        tbl[21] = '{3'b001, 3'b000, 3'b000, 1'b1, 2'd0};
        tbl[22] = '{3'b000, 3'b000, 3'b001, 1'b0, 2'd0};
        tbl[23] = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd0};

        rst       = 1'b1;
        req       = '0;
        lock      = '0;
        req_write = '0;
        addr_a[0] = 24'h000130; addr_a[1] = 24'h000202; addr_a[2] = 24'h000300;
        wdata_a[0] = 32'h11111111; wdata_a[1] = 32'h22222222; wdata_a[2] = 32'h33333333;
        width_a[0] = 2'b10; width_a[1] = 2'b10; width_a[2] = 2'b10;

        repeat (3) step();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_read", 32'(io_read), 32'h0);
        chk("rst_write", 32'(io_write), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr", 32'(io_addr), 32'h0);

        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            req  = tbl[i].req;
            lock = tbl[i].lock;
            step();
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("v%0d_read", i), 32'(io_read), 32'(tbl[i].rd));
            chk($sformatf("v%0d_write", i), 32'(io_write), 32'h0);
            chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(tbl[i].gid));
            if (i == 0) chk("read_addr", 32'(io_addr), 32'h000130);
            if (i == 1) chk("read_rdata", rdata, 32'hA5000130);
            if (i == 19) chk("lock_rdata", rdata, 32'hA5000300);
        end
        chk("tbl_rdata", rdata, 32'hA5000130);

        // write passthrough by requester 1 (last_grant is 0)
        req_write  = 3'b010;
        wdata_a[1] = 32'h00001234;
        width_a[1] = 2'b01;
        req        = 3'b010;
        step();
        chk("wr_write", 32'(io_write), 32'h1);
        chk("wr_read", 32'(io_read), 32'h0);
        chk("wr_data", io_data_in, 32'h00001234);
        chk("wr_width", 32'(io_width), 32'h1);
        chk("wr_addr", 32'(io_addr), 32'h000202);
        chk("wr_gid", 32'(grant_id), 32'h1);
        req = 3'b000;
        step();
        chk("wr_ack", 32'(ack), 32'h2);
        chk("wr_write_off", 32'(io_write), 32'h0);
        chk("wr_rdata_kept", rdata, 32'hA5000130);
        chk("wr_hold_addr", 32'(io_addr), 32'h000202);
        step();
        req_write = '0;

        // dropped request: requester 0 withdraws req during ACCESS
        req = 3'b001;
        step();
        chk("drop_read", 32'(io_read), 32'h1);
        req = 3'b000;
        step();
        chk("drop_ack", 32'(ack), 32'h1);
        step();
        chk("drop_ack_off", 32'(ack), 32'h0);
        step();
        chk("drop_idle_read", 32'(io_read), 32'h0);
        chk("drop_idle_ack", 32'(ack), 32'h0);

        // reset during a write access by requester 1
        req_write = 3'b010;
        req       = 3'b010;
        step();
        chk("abort_pre_write", 32'(io_write), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_write_masked", 32'(io_write), 32'h0);
        step();
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_write", 32'(io_write), 32'h0);
        chk("abort_read", 32'(io_read), 32'h0);
        rst       = 1'b0;
        req_write = '0;
        req       = 3'b111;
        step();
        chk("abort_next_gid", 32'(grant_id), 32'h0);
        chk("abort_next_read", 32'(io_read), 32'h1);
        req = 3'b000;
        step();
        chk("abort_next_ack", 32'(ack), 32'h1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Strobe exclusivity holds on every cycle.
    always @(negedge clk_mem) begin
        if (io_read && io_write) begin
            failures++;
            $display("FAIL strobe_excl: read=%0b write=%0b expected not both", io_read, io_write);
        end
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single IO-register access port (addr/data_in/data_out/read/write/width) among NUM_REQ requesters: CPU, DMA sequencer, debug/UART loader.
- Round-robin arbitration with a req/ack handshake and an optional bounded lock, so read-modify-write sequences stay atomic.
- Sits between the requesters and the IO register file, clocked on clk_mem.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 has first priority after reset.
- ADDR_W, 24, address width.
- DATA_W, 32, data width.
- MAX_LOCK, 4, maximum consecutive locked grants to one requester before a forced re-arbitration.

Ports:
- clk_mem  in  1  system/memory clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request; level, held until ack.
- lock  in  NUM_REQ  per-requester keep-grant request, sampled with req.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_width  in  NUM_REQ*2  access width: 00 byte, 01 half, others word.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  DATA_W  read data; valid while ack is high.
- grant_id  out  2  index of the current or last granted requester.
- io_addr  out  ADDR_W  to the IO register file.
- io_data_in  out  DATA_W  write data to the IO register file.
- io_data_out  in  DATA_W  combinational read data from the IO register file.
- io_read  out  1  read strobe.
- io_write  out  1  write strobe.
- io_width  out  2  width to the IO register file.

Behaviour:
- Reset values: all outputs 0; ack = 0; state = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first; lock_cnt = 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the first set bit searching last_grant+1, +2, … modulo NUM_REQ.
  - Latch that requester's addr, wdata, write and width into holding registers.
  - Set grant_id = last_grant = winner; go to ACCESS.
  - If no req, stay in IDLE.
- ACCESS: exactly one cycle.
  - io_addr, io_data_in and io_width come from the holding registers.
  - io_write = latched write; io_read = ~latched write.
  - The IO file commits the write on the closing edge; rdata captures io_data_out on the same edge.
  - Go to RESP.
- RESP: ack[grant_id] = 1 for exactly this cycle; io_read = io_write = 0.
  - If req[g] & lock[g] are sampled high this cycle and lock_cnt < MAX_LOCK-1: increment lock_cnt, latch the same requester's new request fields, go directly to ACCESS (no re-arbitration).
  - Otherwise: clear lock_cnt, go to IDLE.
- Latency and throughput:
  - req rising in IDLE at cycle 0 → ACCESS in cycle 1 → ack in cycle 2.
  - Unlocked throughput is one access per 3 cycles; locked is one per 2 cycles.
- Strobe rules:
  - io_read and io_write are never high together.
  - Neither is high outside ACCESS.
  - io_addr, io_data_in and io_width hold their last values between accesses.
- Requester rules:
  - After ack, the requester must drop req or present a new transaction in the same cycle as ack (same-cycle presentation only applies when locking).
  - A req still high after ack without lock is treated as a new request and competes in IDLE.
- req dropped after grant: the transaction still completes and ack still pulses; the requester must ignore it.
- Lock limit: at MAX_LOCK consecutive accesses the lock is broken.
  - Go to IDLE; round-robin from the next index prevents starvation.
  - The locking requester may be re-granted only if no other req is pending.
- lock without req is ignored.
- rdata holds its value until the next read completes; write accesses leave rdata unchanged.
- Reset mid-operation:
  - Abort to IDLE with no ack and strobes low.
  - A write in ACCESS on the reset cycle is suppressed (io_write forced 0 while rst is high).

Test Plan:
- Single read: rst released, req=001, req_addr0=0x000130 → io_read high in cycle 1 only with io_addr=0x000130; ack=001 in cycle 2; rdata equals io_data_out sampled in cycle 1.
- Contention: req=111 held continuously → grant order 0,1,2,0,… with one ack every 3 cycles; each ack one cycle wide; no requester waits more than 2 grants.
- Write passthrough: requester 1 writes wdata=0x00001234, width=01, addr=0x000202 → io_write one cycle, io_data_in=0x00001234, io_width=01; rdata unchanged.
- Lock with MAX_LOCK=4: requester 2 holds req+lock while req0 is also high → four consecutive accesses to 2 at 2-cycle spacing, then requester 0 is granted.
- Abort: rst asserted during ACCESS of a write → io_write 0 in that cycle, no ack, state IDLE; next grant goes to requester 0.
- Dropped request: requester 0 drops req in cycle 1 → ack[0] still pulses in cycle 2; arbiter returns to IDLE.
